// File: rtl/ncc_stream_matcher_if.sv
// Stream bundle for ncc_stream_matcher: descriptor rows, window rows, per-window results, best match.
// Widths derive from the same parameters as the matcher so both sides agree on ACC_W/IDX_W.
interface ncc_stream_matcher_if #(
  parameter int N       = 16,
  parameter int PIX_W   = 8,
  parameter int DESC_W  = 8,
  parameter int NUM_WIN = 150
);
  localparam int ACC_W = DESC_W + PIX_W + 2 * $clog2(N) + 1;
  localparam int IDX_W = $clog2(NUM_WIN);

  logic                  desc_valid;
  logic                  desc_ready;
  logic [N*DESC_W-1:0]   desc_row;
  logic                  desc_reload;
  logic                  win_valid;
  logic                  win_ready;
  logic [N*PIX_W-1:0]    win_row;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_W-1:0]      res_num;
  logic [ACC_W-1:0]      res_dss;
  logic [ACC_W-1:0]      res_wss;
  logic [IDX_W-1:0]      res_idx;
  logic                  frame_done;
  logic [ACC_W-1:0]      best_num;
  logic [ACC_W-1:0]      best_wss;
  logic [IDX_W-1:0]      best_idx;

  modport master (
    output desc_valid, desc_row, desc_reload, win_valid, win_row, res_ready,
    input  desc_ready, win_ready, res_valid, res_num, res_dss, res_wss, res_idx,
           frame_done, best_num, best_wss, best_idx
  );

  modport slave (
    input  desc_valid, desc_row, desc_reload, win_valid, win_row, res_ready,
    output desc_ready, win_ready, res_valid, res_num, res_dss, res_wss, res_idx,
           frame_done, best_num, best_wss, best_idx
  );
endinterface

// File: rtl/ncc_stream_matcher.sv
// Streaming NCC matcher: exact sum(d*w), sum(d^2), sum(w^2) per window against a stored descriptor.
// Define NCC_BEST_TRACK_EN to build the per-frame best-window tracker; otherwise best_* are tied to 0.
module ncc_stream_matcher #(
  parameter int N       = 16,
  parameter int PIX_W   = 8,
  parameter int DESC_W  = 8,
  parameter int NUM_WIN = 150
) (
  input logic                clk,
  input logic                rst_n,
  ncc_stream_matcher_if.slave bus
);
  localparam int ACC_W = DESC_W + PIX_W + 2 * $clog2(N) + 1;
  localparam int IDX_W = $clog2(NUM_WIN);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_WIN = IDX_W'(NUM_WIN - 1);

  typedef enum logic [2:0] {DESC_LOAD, WIN_IDLE, WIN_ACC, DRAIN, RESULT} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        desc_cnt, win_cnt;
  logic [N*DESC_W-1:0]     desc_mem [N];
  logic [ACC_W-1:0]        dss;
  logic                    s1_valid, s1_first;
  logic signed [ACC_W-1:0] s1_num, acc_num;
  logic [ACC_W-1:0]        s1_wss, acc_wss;
  logic [IDX_W-1:0]        res_idx;
  logic                    frame_done;

  logic desc_ready, win_ready, res_valid;
  logic desc_fire, win_fire, res_fire, reload_take;

  logic signed [ACC_W-1:0] wd [N];
  logic signed [ACC_W-1:0] ww [N];
  logic signed [ACC_W-1:0] dd [N];
  logic signed [ACC_W-1:0] row_num;
  logic [ACC_W-1:0]        row_wss, row_dss;

  assign desc_fire   = bus.desc_valid & desc_ready;
  assign win_fire    = bus.win_valid & win_ready;
  assign res_fire    = res_valid & bus.res_ready;
  assign reload_take = (state == WIN_IDLE) & bus.desc_reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DESC_LOAD;
    else        state <= state_nxt;
  end

  // A reload request in WIN_IDLE takes priority over a waiting window beat.
  always_comb begin
    state_nxt = state;
    case (state)
      DESC_LOAD: if (desc_fire && desc_cnt == LAST_ROW) state_nxt = WIN_IDLE;
      WIN_IDLE: begin
        if (bus.desc_reload)    state_nxt = DESC_LOAD;
        else if (bus.win_valid) state_nxt = (win_cnt == LAST_ROW) ? DRAIN : WIN_ACC;
      end
      WIN_ACC:   if (win_fire && win_cnt == LAST_ROW) state_nxt = DRAIN;
      DRAIN:     state_nxt = RESULT;
      RESULT:    if (bus.res_ready) state_nxt = WIN_IDLE;
      default:   state_nxt = DESC_LOAD;
    endcase
  end

  always_comb begin
    desc_ready = (state == DESC_LOAD);
    win_ready  = ((state == WIN_IDLE) && !bus.desc_reload) || (state == WIN_ACC);
    res_valid  = (state == RESULT);
  end

  // Stage 1 row sums; descriptor pixels sign-extend, window pixels zero-extend.
  always_comb begin
    row_num = '0;
    row_wss = '0;
    row_dss = '0;
    for (int i = 0; i < N; i++) begin
      wd[i] = {{(ACC_W-DESC_W){desc_mem[win_cnt][i*DESC_W+DESC_W-1]}},
               desc_mem[win_cnt][i*DESC_W +: DESC_W]};
      ww[i] = {{(ACC_W-PIX_W){1'b0}}, bus.win_row[i*PIX_W +: PIX_W]};
      dd[i] = {{(ACC_W-DESC_W){bus.desc_row[i*DESC_W+DESC_W-1]}},
               bus.desc_row[i*DESC_W +: DESC_W]};
      row_num = row_num + wd[i] * ww[i];
      row_wss = row_wss + ww[i] * ww[i];
      row_dss = row_dss + dd[i] * dd[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) desc_mem[r] <= '0;
      desc_cnt   <= '0;
      win_cnt    <= '0;
      dss        <= '0;
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_num     <= '0;
      s1_wss     <= '0;
      acc_num    <= '0;
      acc_wss    <= '0;
      res_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (desc_fire) begin
        desc_mem[desc_cnt] <= bus.desc_row;
        desc_cnt <= (desc_cnt == LAST_ROW) ? '0 : desc_cnt + 1'b1;
        dss      <= (desc_cnt == '0) ? row_dss : dss + row_dss;
      end
      s1_valid <= win_fire;
      if (win_fire) begin
        s1_num   <= row_num;
        s1_wss   <= row_wss;
        s1_first <= (win_cnt == '0);
        win_cnt  <= (win_cnt == LAST_ROW) ? '0 : win_cnt + 1'b1;
      end
      if (s1_valid) begin
        acc_num <= s1_first ? s1_num : acc_num + s1_num;
        acc_wss <= s1_first ? s1_wss : acc_wss + s1_wss;
      end
      if (reload_take)   res_idx <= '0;
      else if (res_fire) res_idx <= (res_idx == LAST_WIN) ? '0 : res_idx + 1'b1;
      frame_done <= res_fire && (res_idx == LAST_WIN);
    end
  end

  assign bus.desc_ready = desc_ready;
  assign bus.win_ready  = win_ready;
  assign bus.res_valid  = res_valid;
  assign bus.res_num    = acc_num;
  assign bus.res_dss    = dss;
  assign bus.res_wss    = acc_wss;
  assign bus.res_idx    = res_idx;
  assign bus.frame_done = frame_done;

`ifdef NCC_BEST_TRACK_EN
  logic [ACC_W-1:0]   best_num_q, best_wss_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic [3*ACC_W-1:0] cur_num_x, cur_wss_x, best_num_x, best_wss_x, lhs, rhs;
  logic               cand;

  // Cross-multiplied squared-NCC compare; dss is common to both sides and drops out.
  assign cur_num_x  = {{(2*ACC_W){1'b0}}, acc_num};
  assign cur_wss_x  = {{(2*ACC_W){1'b0}}, acc_wss};
  assign best_num_x = {{(2*ACC_W){1'b0}}, best_num_q};
  assign best_wss_x = {{(2*ACC_W){1'b0}}, best_wss_q};
  assign lhs        = cur_num_x * cur_num_x * best_wss_x;
  assign rhs        = best_num_x * best_num_x * cur_wss_x;
  assign cand       = !acc_num[ACC_W-1] && (acc_num != '0) && (acc_wss != '0);

  // An empty best (wss 0) is replaced by the first candidate of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_num_q <= '0;
      best_wss_q <= '0;
      best_idx_q <= '0;
    end else if (res_fire) begin
      if (res_idx == '0) begin
        best_num_q <= cand ? acc_num : '0;
        best_wss_q <= cand ? acc_wss : '0;
        best_idx_q <= '0;
      end else if (cand && ((best_wss_q == '0) || (lhs > rhs))) begin
        best_num_q <= acc_num;
        best_wss_q <= acc_wss;
        best_idx_q <= res_idx;
      end
    end
  end

  assign bus.best_num = best_num_q;
  assign bus.best_wss = best_wss_q;
  assign bus.best_idx = best_idx_q;
`else
  assign bus.best_num = '0;
  assign bus.best_wss = '0;
  assign bus.best_idx = '0;
`endif
endmodule

// File: tb/tb_ncc_stream_matcher.sv
// Directed bench for ncc_stream_matcher at N=4, NUM_WIN=4 with hand-computed sums.
// Best-match expectations follow NCC_BEST_TRACK_EN, matching the build of the design.
module tb_ncc_stream_matcher;
  localparam int N       = 4;
  localparam int PIX_W   = 8;
  localparam int DESC_W  = 8;
  localparam int NUM_WIN = 4;
  localparam int ACC_W   = 21;
  localparam int IDX_W   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int fd_cnt = 0;

  ncc_stream_matcher_if #(.N(N), .PIX_W(PIX_W), .DESC_W(DESC_W), .NUM_WIN(NUM_WIN)) bus ();

  ncc_stream_matcher #(.N(N), .PIX_W(PIX_W), .DESC_W(DESC_W), .NUM_WIN(NUM_WIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.frame_done) fd_cnt <= fd_cnt + 1;

  function automatic logic [31:0] pack4(input int p0, input int p1, input int p2, input int p3);
    return {p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
  endfunction

  task automatic send_desc(input logic [31:0] row);
    int t = 0;
    bus.desc_valid = 1'b1;
    bus.desc_row   = row;
    while (!bus.desc_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!bus.desc_ready) begin
      total_cnt++;
      $display("[TB] FAIL desc_accept_timeout desc_ready=%0b required=1", bus.desc_ready);
    end
    @(posedge clk); #1;
    bus.desc_valid = 1'b0;
  endtask

  task automatic send_win(input logic [31:0] row);
    int t = 0;
    bus.win_valid = 1'b1;
    bus.win_row   = row;
    while (!bus.win_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!bus.win_ready) begin
      total_cnt++;
      $display("[TB] FAIL win_accept_timeout win_ready=%0b required=1", bus.win_ready);
    end
    @(posedge clk); #1;
    bus.win_valid = 1'b0;
  endtask

  task automatic wait_result();
    int t = 0;
    while (!bus.res_valid && t < 20) begin @(posedge clk); #1; t++; end
    if (!bus.res_valid) begin
      total_cnt++;
      $display("[TB] FAIL res_valid_timeout res_valid=%0b required=1", bus.res_valid);
    end
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic reload_desc();
    bus.desc_reload = 1'b1;
    @(posedge clk); #1;
    bus.desc_reload = 1'b0;
  endtask

  task automatic test_reset();
    bus.desc_valid = 0; bus.desc_row = '0; bus.desc_reload = 0;
    bus.win_valid = 0; bus.win_row = '0; bus.res_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.res_valid, bus.win_ready, bus.frame_done, bus.res_num, bus.res_dss, bus.res_wss, bus.res_idx} !== '0)
      $display("[TB] FAIL reset_outputs valid=%0b wready=%0b num=%0d dss=%0d wss=%0d idx=%0d required all 0",
               bus.res_valid, bus.win_ready, bus.res_num, bus.res_dss, bus.res_wss, bus.res_idx);
    else pass_cnt++;
    total_cnt++;
    if ({bus.best_num, bus.best_wss, bus.best_idx} !== '0)
      $display("[TB] FAIL reset_best num=%0d wss=%0d idx=%0d required 0", bus.best_num, bus.best_wss, bus.best_idx);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.desc_ready !== 1'b1) $display("[TB] FAIL reset_desc_ready got=%0b required=1", bus.desc_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    for (int r = 0; r < N; r++) send_desc(pack4(1, 1, 1, 1));
    total_cnt++;
    if (bus.desc_ready !== 1'b0) $display("[TB] FAIL basic_desc_ready_drop got=%0b required=0", bus.desc_ready);
    else pass_cnt++;
    for (int r = 0; r < N; r++) send_win(pack4(2, 2, 2, 2));
    total_cnt++;
    if (bus.res_valid !== 1'b0) $display("[TB] FAIL basic_latency_early got=%0b required=0", bus.res_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.res_valid !== 1'b1) $display("[TB] FAIL basic_latency got=%0b required=1", bus.res_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.res_num !== ACC_W'(32)) $display("[TB] FAIL basic_num got=%0d required=32", $signed(bus.res_num));
    else pass_cnt++;
    total_cnt++;
    if (bus.res_dss !== ACC_W'(16)) $display("[TB] FAIL basic_dss got=%0d required=16", bus.res_dss);
    else pass_cnt++;
    total_cnt++;
    if (bus.res_wss !== ACC_W'(64)) $display("[TB] FAIL basic_wss got=%0d required=64", bus.res_wss);
    else pass_cnt++;
    total_cnt++;
    if (bus.res_idx !== IDX_W'(0)) $display("[TB] FAIL basic_idx got=%0d required=0", bus.res_idx);
    else pass_cnt++;
    consume();
    total_cnt++;
    if ({bus.res_valid, bus.win_ready} !== 2'b01)
      $display("[TB] FAIL basic_after_consume valid=%0b wready=%0b required 0/1", bus.res_valid, bus.win_ready);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    reload_desc();
    total_cnt++;
    if ({bus.desc_ready, bus.res_idx} !== {1'b1, IDX_W'(0)})
      $display("[TB] FAIL hold_reload ready=%0b idx=%0d required 1/0", bus.desc_ready, bus.res_idx);
    else pass_cnt++;
    for (int r = 0; r < N; r++) send_desc(pack4(-3, -3, -3, -3));
    for (int r = 0; r < N; r++) send_win(pack4(255, 255, 255, 255));
    wait_result();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (bus.res_valid !== 1'b1 || bus.win_ready !== 1'b0 || bus.res_num !== ACC_W'(-12240) ||
          bus.res_wss !== ACC_W'(1040400))
        $display("[TB] FAIL hold_cycle%0d valid=%0b wready=%0b num=%0d wss=%0d required 1/0/-12240/1040400",
                 c, bus.res_valid, bus.win_ready, $signed(bus.res_num), bus.res_wss);
      else pass_cnt++;
    end
    total_cnt++;
    if ({bus.res_dss, bus.res_idx} !== {ACC_W'(144), IDX_W'(0)})
      $display("[TB] FAIL hold_dss_idx dss=%0d idx=%0d required 144/0", bus.res_dss, bus.res_idx);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_gaps();
    for (int r = 0; r < N; r++) begin
      send_win(pack4(255, 255, 255, 255));
      if (r < N - 1) begin
        @(posedge clk); #1;
        total_cnt++;
        if (bus.win_ready !== 1'b1) $display("[TB] FAIL gaps_hold_acc row%0d wready=%0b required=1", r, bus.win_ready);
        else pass_cnt++;
      end
    end
    wait_result();
    total_cnt++;
    if (bus.res_num !== ACC_W'(-12240) || bus.res_wss !== ACC_W'(1040400) || bus.res_idx !== IDX_W'(1))
      $display("[TB] FAIL gaps_result num=%0d wss=%0d idx=%0d required -12240/1040400/1",
               $signed(bus.res_num), bus.res_wss, bus.res_idx);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_frame();
    logic [31:0] win_tab [4][4];
    int exp_num [4];
    int fd_before;
    win_tab[0] = '{pack4(10, 0, 20, 20), pack4(20, 20, 20, 20), 32'd0, 32'd0};
    win_tab[1] = '{pack4(40, 0, 30, 0), 32'd0, 32'd0, 32'd0};
    win_tab[2] = '{pack4(40, 0, 30, 0), 32'd0, 32'd0, 32'd0};
    win_tab[3] = '{pack4(0, 5, 45, 15), pack4(15, 0, 0, 0), 32'd0, 32'd0};
    exp_num = '{10, 40, 40, -5};
    reload_desc();
    send_desc(pack4(1, -1, 0, 0));
    for (int r = 1; r < N; r++) send_desc(32'd0);
    fd_before = fd_cnt;
    for (int k = 0; k < NUM_WIN; k++) begin
      for (int r = 0; r < N; r++) send_win(win_tab[k][r]);
      wait_result();
      total_cnt++;
      if (bus.res_num !== ACC_W'(exp_num[k]) || bus.res_wss !== ACC_W'(2500) ||
          bus.res_dss !== ACC_W'(2) || bus.res_idx !== IDX_W'(k))
        $display("[TB] FAIL frame_win%0d num=%0d wss=%0d dss=%0d idx=%0d required %0d/2500/2/%0d",
                 k, $signed(bus.res_num), bus.res_wss, bus.res_dss, bus.res_idx, exp_num[k], k);
      else pass_cnt++;
      consume();
    end
    total_cnt++;
    if ({bus.frame_done, bus.res_idx} !== {1'b1, IDX_W'(0)})
      $display("[TB] FAIL frame_done_pulse done=%0b idx=%0d required 1/0", bus.frame_done, bus.res_idx);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.frame_done !== 1'b0 || fd_cnt - fd_before != 1)
      $display("[TB] FAIL frame_done_once done=%0b pulses=%0d required 0/1", bus.frame_done, fd_cnt - fd_before);
    else pass_cnt++;
`ifdef NCC_BEST_TRACK_EN
    total_cnt++;
    if (bus.best_idx !== IDX_W'(1) || bus.best_num !== ACC_W'(40) || bus.best_wss !== ACC_W'(2500))
      $display("[TB] FAIL frame_best idx=%0d num=%0d wss=%0d required 1/40/2500",
               bus.best_idx, bus.best_num, bus.best_wss);
    else pass_cnt++;
`else
    total_cnt++;
    if ({bus.best_idx, bus.best_num, bus.best_wss} !== '0)
      $display("[TB] FAIL frame_best_off idx=%0d num=%0d wss=%0d required 0",
               bus.best_idx, bus.best_num, bus.best_wss);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reload();
    send_win(pack4(1, 1, 1, 1));
    bus.desc_reload = 1'b1;
    @(posedge clk); #1;
    bus.desc_reload = 1'b0;
    total_cnt++;
    if ({bus.desc_ready, bus.win_ready} !== 2'b01)
      $display("[TB] FAIL reload_in_acc dready=%0b wready=%0b required 0/1", bus.desc_ready, bus.win_ready);
    else pass_cnt++;
    for (int r = 1; r < N; r++) send_win(32'd0);
    wait_result();
    total_cnt++;
    if (bus.res_num !== ACC_W'(0) || bus.res_wss !== ACC_W'(4) || bus.res_idx !== IDX_W'(0))
      $display("[TB] FAIL reload_acc_result num=%0d wss=%0d idx=%0d required 0/4/0",
               $signed(bus.res_num), bus.res_wss, bus.res_idx);
    else pass_cnt++;
    consume();
    bus.win_valid   = 1'b1;
    bus.win_row     = pack4(9, 9, 9, 9);
    bus.desc_reload = 1'b1;
    #1;
    total_cnt++;
    if (bus.win_ready !== 1'b0) $display("[TB] FAIL reload_beats_win wready=%0b required=0", bus.win_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.win_valid   = 1'b0;
    bus.desc_reload = 1'b0;
    total_cnt++;
    if ({bus.desc_ready, bus.win_ready, bus.res_idx} !== {2'b10, IDX_W'(0)})
      $display("[TB] FAIL reload_idle dready=%0b wready=%0b idx=%0d required 1/0/0",
               bus.desc_ready, bus.win_ready, bus.res_idx);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < N; r++) send_desc(pack4(1, 1, 1, 1));
    send_win(pack4(3, 3, 3, 3));
    send_win(pack4(3, 3, 3, 3));
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.res_valid, bus.win_ready, bus.frame_done, bus.res_num, bus.res_dss, bus.res_wss, bus.res_idx,
         bus.best_num, bus.best_wss, bus.best_idx} !== '0 || bus.desc_ready !== 1'b1)
      $display("[TB] FAIL reset_mid num=%0d dss=%0d wss=%0d idx=%0d wready=%0b dready=%0b required 0s, dready 1",
               bus.res_num, bus.res_dss, bus.res_wss, bus.res_idx, bus.win_ready, bus.desc_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({bus.desc_ready, bus.win_ready} !== 2'b10)
      $display("[TB] FAIL reset_mid_release dready=%0b wready=%0b required 1/0", bus.desc_ready, bus.win_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_gaps();
    test_frame();
    test_reload();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
